tribus_arbiter: RTL and testbench

Round-robin arbiter that shares one multi-driver tri-state bus (tri/wor/wand net) among N_REQ requesters. Exactly one requester's output-enable is active at a time. A forced all-released turnaround gap separates owners, so the bus never sees overlapping drivers. The block sits beside the shared net. Each requester gates its driver with its oe bit (`oe ? data : 'bz`).

---
 rtl/tribus_arbiter.sv | 137 +++++++++++++
 tb/tb_tribus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus, with a forced turnaround gap.
// Ports: clk, rst_n, req[N_REQ], gnt/oe[N_REQ] one-hot, owner_id, bus_busy. Option macro: HOLD_TIMEOUT_EN.
module tribus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TA_CYCLES = 1,
  parameter int MAX_HOLD  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         oe,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     bus_busy
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("tribus_arbiter: N_REQ out of range");
  end
  if (TA_CYCLES < 1 || TA_CYCLES > 15) begin : g_bad_ta
    $error("tribus_arbiter: TA_CYCLES out of range");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("tribus_arbiter: MAX_HOLD out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [3:0]      ta_cnt;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic [N_REQ-1:0] win_oh;
  logic            preempt;

  // Search starts one past the last winner and wraps.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      logic [IW-1:0] k;
      k = IW'((int'(ptr) + i) % N_REQ);
      if (!win_vld && req[k]) begin
        win_vld = 1'b1;
        win     = k;
      end
    end
  end

  assign win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win;

`ifdef HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Only give the bus away when someone else is actually waiting.
  assign preempt = (hold_cnt == 8'(MAX_HOLD)) && |(req & ~gnt);
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      oe       <= '0;
      owner_id <= '0;
      bus_busy <= 1'b0;
      ptr      <= IW'(N_REQ - 1);
      ta_cnt   <= '0;
`ifdef HOLD_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= GRANT;
            gnt      <= win_oh;
            oe       <= win_oh;
            owner_id <= win;
            ptr      <= win;
            bus_busy <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt <= 8'd1;
`endif
          end
        end
        GRANT: begin
          if (!req[owner_id] || preempt) begin
            state  <= TURN;
            gnt    <= '0;
            oe     <= '0;
            ta_cnt <= 4'(TA_CYCLES);
          end
`ifdef HOLD_TIMEOUT_EN
          else if (hold_cnt != 8'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        TURN: begin
          if (ta_cnt == 4'd1) begin
            if (win_vld) begin
              state    <= GRANT;
              gnt      <= win_oh;
              oe       <= win_oh;
              owner_id <= win;
              ptr      <= win;
`ifdef HOLD_TIMEOUT_EN
              hold_cnt <= 8'd1;
`endif
            end else begin
              state    <= IDLE;
              bus_busy <= 1'b0;
            end
          end else begin
            ta_cnt <= ta_cnt - 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          oe       <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench for tribus_arbiter: two instances (turnaround 1 and 3).
// Expected outputs are queued as stimulus is driven and checked after each edge.
module tb_tribus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = '0;
  logic [3:0] gnt_a, oe_a;
  logic [1:0] own_a;
  logic       busy_a;
  logic [3:0] req_b = '0;
  logic [3:0] gnt_b, oe_b;
  logic [1:0] own_b;
  logic       busy_b;

  logic [3:0] prev_oe_a = '0;
  logic [3:0] prev_oe_b = '0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] own;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  tribus_arbiter #(.N_REQ(4), .TA_CYCLES(1), .MAX_HOLD(8)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_a),
    .gnt      (gnt_a),
    .oe       (oe_a),
    .owner_id (own_a),
    .bus_busy (busy_a)
  );

  tribus_arbiter #(.N_REQ(4), .TA_CYCLES(3), .MAX_HOLD(8)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_b),
    .gnt      (gnt_b),
    .oe       (oe_b),
    .owner_id (own_b),
    .bus_busy (busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [3:0] g, input logic b, input logic [1:0] o);
    exp_t e;
    e.gnt = g; e.busy = b; e.own = o;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] g, input logic b, input logic [1:0] o);
    exp_t e;
    e.gnt = g; e.busy = b; e.own = o;
    qb.push_back(e);
  endtask

  task automatic pop_a();
    exp_t e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      chk("a_gnt", gnt_a, e.gnt);
      chk("a_oe", oe_a, e.gnt);
      chk("a_busy", busy_a, e.busy);
      chk("a_owner", own_a, e.own);
    end
  endtask

  task automatic pop_b();
    exp_t e;
    if (qb.size() != 0) begin
      e = qb.pop_front();
      chk("b_gnt", gnt_b, e.gnt);
      chk("b_oe", oe_b, e.gnt);
      chk("b_busy", busy_b, e.busy);
      chk("b_owner", own_b, e.own);
    end
  endtask

  task automatic invariants();
    chk("a_oe_eq_gnt", oe_a, gnt_a);
    chk("a_oe_onehot0", 32'($countones(oe_a) <= 1), 1);
    chk("a_no_switch", 32'(prev_oe_a != 0 && oe_a != 0 && prev_oe_a != oe_a), 0);
    chk("b_oe_eq_gnt", oe_b, gnt_b);
    chk("b_oe_onehot0", 32'($countones(oe_b) <= 1), 1);
    chk("b_no_switch", 32'(prev_oe_b != 0 && oe_b != 0 && prev_oe_b != oe_b), 0);
    prev_oe_a = oe_a;
    prev_oe_b = oe_b;
  endtask

  // One clock: sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    pop_a();
    pop_b();
    invariants();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst_n is low
    #3;
    push_a(4'b0000, 1'b0, 2'd0);
    pop_a();
    push_b(4'b0000, 1'b0, 2'd0);
    pop_b();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request to requester 2
    req_a = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      push_a(4'b0100, 1'b1, 2'd2);
      cyc();
    end
    req_a = 4'b0000;
    push_a(4'b0000, 1'b1, 2'd2);
    cyc();
    push_a(4'b0000, 1'b0, 2'd2);
    cyc();

    // Grant to 1, then asynchronous reset mid-grant
    req_a = 4'b0010;
    push_a(4'b0010, 1'b1, 2'd1);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    push_a(4'b0000, 1'b0, 2'd0);
    pop_a();
    req_a = 4'b0000;
    #2;
    rst_n = 1'b1;
    cyc();

    // All request: order 0,1,2,3 with one gap cycle each
    req_a = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        push_a(4'(1 << k), 1'b1, 2'(k));
        cyc();
      end
      req_a[k] = 1'b0;
      push_a(4'b0000, 1'b1, 2'(k));
      cyc();
    end
    push_a(4'b0000, 1'b0, 2'd3);
    cyc();

    // Fairness wrap: last owner 3, req 1001 -> 0 then 3
    req_a = 4'b1001;
    push_a(4'b0001, 1'b1, 2'd0);
    cyc();
    req_a = 4'b1000;
    push_a(4'b0000, 1'b1, 2'd0);
    cyc();
    push_a(4'b1000, 1'b1, 2'd3);
    cyc();
    req_a = 4'b0000;
    push_a(4'b0000, 1'b1, 2'd3);
    cyc();
    push_a(4'b0000, 1'b0, 2'd3);
    cyc();

    // Three-cycle turnaround handover 1 -> 3 without IDLE
    req_b = 4'b0010;
    push_b(4'b0010, 1'b1, 2'd1);
    cyc();
    req_b = 4'b1010;
    push_b(4'b0010, 1'b1, 2'd1);
    cyc();
    req_b = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      push_b(4'b0000, 1'b1, 2'd1);
      cyc();
    end
    push_b(4'b1000, 1'b1, 2'd3);
    cyc();
    req_b = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      push_b(4'b0000, 1'b1, 2'd3);
      cyc();
    end
    push_b(4'b0000, 1'b0, 2'd3);
    cyc();

    // Hold timeout: owner 0 holds, requester 1 waits
    req_a = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      push_a(4'b0001, 1'b1, 2'd0);
      cyc();
    end
    req_a = 4'b0011;
`ifdef HOLD_TIMEOUT_EN
    for (int i = 0; i < 6; i++) begin
      push_a(4'b0001, 1'b1, 2'd0);
      cyc();
    end
    push_a(4'b0000, 1'b1, 2'd0);
    cyc();
    push_a(4'b0010, 1'b1, 2'd1);
    cyc();
    req_a = 4'b0000;
    push_a(4'b0000, 1'b1, 2'd1);
    cyc();
    push_a(4'b0000, 1'b0, 2'd1);
    cyc();
`else
    for (int i = 0; i < 48; i++) begin
      push_a(4'b0001, 1'b1, 2'd0);
      cyc();
    end
    req_a = 4'b0000;
    push_a(4'b0000, 1'b1, 2'd0);
    cyc();
    push_a(4'b0000, 1'b0, 2'd0);
    cyc();
`endif

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
